// File: rtl/ctrl_decode_if.sv
// Handshake and decoded-control bundle for ctrl_decode_pipe.
// master drives the instruction stream and consumes the decode; slave is the decoder.
interface ctrl_decode_if #(
    parameter int ALU_CTRL_W = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic                  flush;
    logic                  out_ready;
    logic                  out_valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic                  alu_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] dest;
    logic                  hazard;
    logic [CNT_W-1:0]      ill_cnt;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, reg_write, mem_read, mem_write, branch, jump,
               alu_src, alu_control, rs, rt, dest, hazard, ill_cnt
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, reg_write, mem_read, mem_write, branch, jump,
               alu_src, alu_control, rs, rt, dest, hazard, ill_cnt
    );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// One-stage MIPS control decoder with load-use bubble insertion and illegal-opcode counter.
// Define CTRL_DECODE_EXT_OPS_EN to make ADDI, ORI, BNE and JAL legal.
module ctrl_decode_pipe #(
    parameter int ALU_CTRL_W = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 8
) (
    input logic         clk,
    input logic         rst,
    ctrl_decode_if.slave bus
);
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  alu_src;
        logic [ALU_CTRL_W-1:0] alu_control;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dest;
    } dec_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_DECODE_EXT_OPS_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

    function automatic logic [ALU_CTRL_W-1:0] alu_enc(input logic [2:0] code);
        return ALU_CTRL_W'(code);
    endfunction

    function automatic logic [REG_ADDR_W-1:0] reg_fit(input logic [4:0] r);
        return REG_ADDR_W'(r);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [5:0] opcode_p0;
    logic [5:0] funct_p0;
    dec_t       dec_p0;
    logic       illegal_p0;
    logic       uses_rt_p0;
    logic       unused_shamt_p0;

    dec_t             dec_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] ill_cnt_p1;

    logic load_en;
    logic hazard;
    logic in_ready;
    logic accept;

    assign opcode_p0       = bus.instr[31:26];
    assign funct_p0        = bus.instr[5:0];
    assign unused_shamt_p0 = ^bus.instr[10:6];

    // Stage p0: combinational decode of the incoming instruction word
    always_comb begin
        dec_p0     = '0;
        illegal_p0 = 1'b0;
        uses_rt_p0 = 1'b0;
        dec_p0.rs  = reg_fit(bus.instr[25:21]);
        dec_p0.rt  = reg_fit(bus.instr[20:16]);
        case (opcode_p0)
            OP_RTYPE: begin
                dec_p0.reg_write = 1'b1;
                dec_p0.dest      = reg_fit(bus.instr[15:11]);
                uses_rt_p0       = 1'b1;
                case (funct_p0)
                    6'b100010: dec_p0.alu_control = alu_enc(3'd1);
                    6'b100100: dec_p0.alu_control = alu_enc(3'd2);
                    6'b101000: dec_p0.alu_control = alu_enc(3'd3);
                    6'b110000: dec_p0.alu_control = alu_enc(3'd4);
                    default:   dec_p0.alu_control = alu_enc(3'd0);
                endcase
            end
            OP_LW: begin
                dec_p0.reg_write = 1'b1;
                dec_p0.mem_read  = 1'b1;
                dec_p0.alu_src   = 1'b1;
                dec_p0.dest      = reg_fit(bus.instr[20:16]);
            end
            OP_SW: begin
                dec_p0.mem_write = 1'b1;
                dec_p0.alu_src   = 1'b1;
                uses_rt_p0       = 1'b1;
            end
            OP_BEQ: begin
                dec_p0.branch      = 1'b1;
                dec_p0.alu_control = alu_enc(3'd1);
                uses_rt_p0         = 1'b1;
            end
            OP_J: dec_p0.jump = 1'b1;
`ifdef CTRL_DECODE_EXT_OPS_EN
            OP_ADDI: begin
                dec_p0.reg_write = 1'b1;
                dec_p0.alu_src   = 1'b1;
                dec_p0.dest      = reg_fit(bus.instr[20:16]);
            end
            OP_ORI: begin
                dec_p0.reg_write   = 1'b1;
                dec_p0.alu_src     = 1'b1;
                dec_p0.alu_control = alu_enc(3'd3);
                dec_p0.dest        = reg_fit(bus.instr[20:16]);
            end
            OP_BNE: begin
                dec_p0.branch      = 1'b1;
                dec_p0.alu_control = alu_enc(3'd5);
                uses_rt_p0         = 1'b1;
            end
            OP_JAL: begin
                dec_p0.jump      = 1'b1;
                dec_p0.reg_write = 1'b1;
                dec_p0.dest      = reg_fit(5'd31);
            end
`endif
            default: illegal_p0 = 1'b1;
        endcase
        // Writes to $0 are architecturally dropped, so never advertise them.
        if (dec_p0.dest == '0) dec_p0.reg_write = 1'b0;
    end

    // A load still sitting on the output cannot forward to a consumer in the same cycle.
    assign load_en  = bus.out_ready | ~vld_p1;
    assign hazard   = bus.in_valid & vld_p1 & dec_p1.mem_read & (dec_p1.dest != '0) &
                      ((dec_p1.dest == dec_p0.rs) | (uses_rt_p0 & (dec_p1.dest == dec_p0.rt)));
    assign in_ready = load_en & ~hazard & ~bus.flush;
    assign accept   = bus.in_valid & in_ready;

    // Stage p1: registered decode; bubbles and idle cycles load an all-zero record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            dec_p1     <= '0;
            ill_cnt_p1 <= '0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
            dec_p1 <= '0;
        end else if (load_en) begin
            vld_p1 <= accept;
            dec_p1 <= accept ? dec_p0 : '0;
            if (accept && illegal_p0) ill_cnt_p1 <= sat_inc(ill_cnt_p1);
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.hazard      = hazard;
    assign bus.out_valid   = vld_p1;
    assign bus.reg_write   = dec_p1.reg_write;
    assign bus.mem_read    = dec_p1.mem_read;
    assign bus.mem_write   = dec_p1.mem_write;
    assign bus.branch      = dec_p1.branch;
    assign bus.jump        = dec_p1.jump;
    assign bus.alu_src     = dec_p1.alu_src;
    assign bus.alu_control = dec_p1.alu_control;
    assign bus.rs          = dec_p1.rs;
    assign bus.rt          = dec_p1.rt;
    assign bus.dest        = dec_p1.dest;
    assign bus.ill_cnt     = ill_cnt_p1;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed testbench for ctrl_decode_pipe with hand-computed expectations.
// Control vector order in ctl: {out_valid, reg_write, mem_read, mem_write, branch, jump, alu_src}.
module tb_ctrl_decode_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    ctrl_decode_if bus ();
    ctrl_decode_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [6:0] ctl;
    assign ctl = {bus.out_valid, bus.reg_write, bus.mem_read, bus.mem_write,
                  bus.branch, bus.jump, bus.alu_src};

    logic [5:0] fn_t  [7] = '{6'h20, 6'h22, 6'h24, 6'h28, 6'h30, 6'h27, 6'h20};
    logic [4:0] rd_t  [7] = '{5'd3, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd0};
    logic [2:0] alu_t [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    logic       wr_t  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins);
        bus.in_valid = v;
        bus.instr    = ins;
        #1;
    endtask

    task automatic test_reset;
        bus.in_valid = 1'b0; bus.instr = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_total++; if (ctl !== 7'b0) $display("FAIL reset_ctl got %b want %b", ctl, 7'b0); else n_pass++;
        n_total++; if ({bus.alu_control, bus.rs, bus.rt, bus.dest} !== 18'd0)
            $display("FAIL reset_fields got %h want 0", {bus.alu_control, bus.rs, bus.rt, bus.dest}); else n_pass++;
        n_total++; if (bus.ill_cnt !== 8'd0) $display("FAIL reset_ill_cnt got %0d want 0", bus.ill_cnt); else n_pass++;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.hazard !== 1'b0) $display("FAIL reset_hazard got %b want 0", bus.hazard); else n_pass++;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_rtype;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, rtype(5'd1, 5'd2, rd_t[i], fn_t[i]));
            tick;
            n_total++; if (ctl !== {1'b1, wr_t[i], 5'b0})
                $display("FAIL rtype_ctl[%0d] got %b want %b", i, ctl, {1'b1, wr_t[i], 5'b0}); else n_pass++;
            n_total++; if (bus.alu_control !== alu_t[i])
                $display("FAIL rtype_alu[%0d] got %0d want %0d", i, bus.alu_control, alu_t[i]); else n_pass++;
            n_total++; if ({bus.rs, bus.rt, bus.dest} !== {5'd1, 5'd2, rd_t[i]})
                $display("FAIL rtype_regs[%0d] got %h want %h", i, {bus.rs, bus.rt, bus.dest}, {5'd1, 5'd2, rd_t[i]}); else n_pass++;
        end
        drive(1'b0, '0);
        tick;
        n_total++; if (ctl !== 7'b0) $display("FAIL idle_ctl got %b want 0", ctl); else n_pass++;
    endtask

    task automatic test_load_use;
        drive(1'b1, itype(6'h23, 5'd1, 5'd4, 16'd0));
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL lu_ready0 got %b want 1", bus.in_ready); else n_pass++;
        tick;
        n_total++; if (ctl !== 7'b1110001) $display("FAIL lu_lw_ctl got %b want 1110001", ctl); else n_pass++;
        n_total++; if (bus.dest !== 5'd4) $display("FAIL lu_lw_dest got %0d want 4", bus.dest); else n_pass++;
        drive(1'b1, rtype(5'd4, 5'd2, 5'd5, 6'h20));
        n_total++; if ({bus.hazard, bus.in_ready} !== 2'b10)
            $display("FAIL lu_hazard got %b want 10", {bus.hazard, bus.in_ready}); else n_pass++;
        tick;
        n_total++; if (ctl !== 7'b0) $display("FAIL lu_bubble got %b want 0", ctl); else n_pass++;
        n_total++; if ({bus.hazard, bus.in_ready} !== 2'b01)
            $display("FAIL lu_after_bubble got %b want 01", {bus.hazard, bus.in_ready}); else n_pass++;
        tick;
        n_total++; if ({ctl, bus.dest} !== {7'b1100000, 5'd5})
            $display("FAIL lu_add_out got %h want %h", {ctl, bus.dest}, {7'b1100000, 5'd5}); else n_pass++;
        drive(1'b1, itype(6'h23, 5'd1, 5'd0, 16'd0));
        tick;
        n_total++; if ({ctl, bus.dest} !== {7'b1010001, 5'd0})
            $display("FAIL lu_lw0_out got %h want %h", {ctl, bus.dest}, {7'b1010001, 5'd0}); else n_pass++;
        drive(1'b1, rtype(5'd4, 5'd2, 5'd5, 6'h20));
        n_total++; if ({bus.hazard, bus.in_ready} !== 2'b01)
            $display("FAIL lu_lw0_nohazard got %b want 01", {bus.hazard, bus.in_ready}); else n_pass++;
        tick;
        n_total++; if ({ctl, bus.dest} !== {7'b1100000, 5'd5})
            $display("FAIL lu_lw0_add got %h want %h", {ctl, bus.dest}, {7'b1100000, 5'd5}); else n_pass++;
        drive(1'b1, itype(6'h23, 5'd1, 5'd4, 16'd0));
        tick;
        drive(1'b1, itype(6'h2B, 5'd1, 5'd4, 16'd8));
        n_total++; if (bus.hazard !== 1'b1) $display("FAIL lu_sw_rt_hazard got %b want 1", bus.hazard); else n_pass++;
        tick;
        n_total++; if (ctl !== 7'b0) $display("FAIL lu_sw_bubble got %b want 0", ctl); else n_pass++;
        tick;
        n_total++; if (ctl !== 7'b1001001) $display("FAIL lu_sw_out got %b want 1001001", ctl); else n_pass++;
        drive(1'b1, itype(6'h23, 5'd1, 5'd4, 16'd0));
        tick;
        drive(1'b1, itype(6'h23, 5'd1, 5'd4, 16'd4));
        n_total++; if (bus.hazard !== 1'b0) $display("FAIL lu_lw_rt_nohazard got %b want 0", bus.hazard); else n_pass++;
        tick;
        n_total++; if (ctl !== 7'b1110001) $display("FAIL lu_lw_lw_out got %b want 1110001", ctl); else n_pass++;
        drive(1'b0, '0);
        tick;
    endtask

    task automatic test_backpressure;
        drive(1'b1, itype(6'h2B, 5'd1, 5'd2, 16'd4));
        tick;
        n_total++; if (ctl !== 7'b1001001) $display("FAIL bp_sw_out got %b want 1001001", ctl); else n_pass++;
        bus.out_ready = 1'b0;
        drive(1'b1, itype(6'h04, 5'd3, 5'd5, 16'd8));
        for (int k = 0; k < 3; k++) begin
            n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", k, bus.in_ready); else n_pass++;
            tick;
            n_total++; if ({ctl, bus.rs, bus.rt} !== {7'b1001001, 5'd1, 5'd2})
                $display("FAIL bp_hold[%0d] got %h want %h", k, {ctl, bus.rs, bus.rt}, {7'b1001001, 5'd1, 5'd2}); else n_pass++;
        end
        bus.out_ready = 1'b1;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", bus.in_ready); else n_pass++;
        tick;
        n_total++; if ({ctl, bus.alu_control, bus.rs, bus.rt} !== {7'b1000100, 3'd1, 5'd3, 5'd5})
            $display("FAIL bp_beq_out got %h want %h", {ctl, bus.alu_control, bus.rs, bus.rt},
                     {7'b1000100, 3'd1, 5'd3, 5'd5}); else n_pass++;
        drive(1'b0, '0);
        tick;
    endtask

    task automatic test_flush;
        drive(1'b1, itype(6'h23, 5'd1, 5'd4, 16'd0));
        tick;
        n_total++; if (ctl !== 7'b1110001) $display("FAIL fl_lw_out got %b want 1110001", ctl); else n_pass++;
        bus.flush = 1'b1;
        drive(1'b1, itype(6'h04, 5'd3, 5'd5, 16'd8));
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL fl_in_ready got %b want 0", bus.in_ready); else n_pass++;
        tick;
        n_total++; if (ctl !== 7'b0) $display("FAIL fl_cleared got %b want 0", ctl); else n_pass++;
        bus.flush = 1'b0;
        #1;
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL fl_ready_after got %b want 1", bus.in_ready); else n_pass++;
        tick;
        n_total++; if ({ctl, bus.rs, bus.rt} !== {7'b1000100, 5'd3, 5'd5})
            $display("FAIL fl_beq_out got %h want %h", {ctl, bus.rs, bus.rt}, {7'b1000100, 5'd3, 5'd5}); else n_pass++;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        drive(1'b1, {6'h3F, 26'd0});
        tick;
        n_total++; if ({ctl, bus.ill_cnt} !== {7'b0, 8'd0})
            $display("FAIL fl_stalled_illegal got %h want 0", {ctl, bus.ill_cnt}); else n_pass++;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0);
        tick;
        n_total++; if ({ctl, bus.ill_cnt} !== {7'b0, 8'd0})
            $display("FAIL fl_idle_after got %h want 0", {ctl, bus.ill_cnt}); else n_pass++;
    endtask

    task automatic test_illegal;
        int         bad;
        logic [7:0] exp_cnt;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, {6'h3F, 26'(i)});
            tick;
            exp_cnt = (i + 1 > 255) ? 8'hFF : 8'(i + 1);
            if (ctl !== 7'b1000000 || bus.dest !== 5'd0 || bus.ill_cnt !== exp_cnt) bad++;
        end
        n_total++; if (bad !== 0) $display("FAIL ill_stream bad_cycles got %0d want 0", bad); else n_pass++;
        n_total++; if (bus.ill_cnt !== 8'hFF) $display("FAIL ill_saturate got %0d want 255", bus.ill_cnt); else n_pass++;
        drive(1'b0, '0);
        tick;
        n_total++; if ({ctl, bus.ill_cnt} !== {7'b0, 8'hFF})
            $display("FAIL ill_idle got %h want %h", {ctl, bus.ill_cnt}, {7'b0, 8'hFF}); else n_pass++;
    endtask

    task automatic test_ext_ops;
        #2 rst = 1'b1;
        #1;
        n_total++; if (bus.ill_cnt !== 8'd0) $display("FAIL ext_reset_cnt got %0d want 0", bus.ill_cnt); else n_pass++;
        #1 rst = 1'b0;
        drive(1'b1, itype(6'h08, 5'd1, 5'd6, 16'd5));
        tick;
`ifdef CTRL_DECODE_EXT_OPS_EN
        n_total++; if ({ctl, bus.alu_control, bus.dest, bus.ill_cnt} !== {7'b1100001, 3'd0, 5'd6, 8'd0})
            $display("FAIL ext_addi got %h want %h", {ctl, bus.alu_control, bus.dest, bus.ill_cnt},
                     {7'b1100001, 3'd0, 5'd6, 8'd0}); else n_pass++;
        drive(1'b1, itype(6'h0D, 5'd1, 5'd9, 16'h00FF));
        tick;
        n_total++; if ({ctl, bus.alu_control, bus.dest} !== {7'b1100001, 3'd3, 5'd9})
            $display("FAIL ext_ori got %h want %h", {ctl, bus.alu_control, bus.dest}, {7'b1100001, 3'd3, 5'd9}); else n_pass++;
        drive(1'b1, itype(6'h05, 5'd3, 5'd5, 16'd8));
        tick;
        n_total++; if ({ctl, bus.alu_control, bus.dest} !== {7'b1000100, 3'd5, 5'd0})
            $display("FAIL ext_bne got %h want %h", {ctl, bus.alu_control, bus.dest}, {7'b1000100, 3'd5, 5'd0}); else n_pass++;
        drive(1'b1, {6'h03, 26'd64});
        tick;
        n_total++; if ({ctl, bus.dest, bus.ill_cnt} !== {7'b1100010, 5'd31, 8'd0})
            $display("FAIL ext_jal got %h want %h", {ctl, bus.dest, bus.ill_cnt}, {7'b1100010, 5'd31, 8'd0}); else n_pass++;
`else
        n_total++; if ({ctl, bus.dest, bus.ill_cnt} !== {7'b1000000, 5'd0, 8'd1})
            $display("FAIL ext_addi_illegal got %h want %h", {ctl, bus.dest, bus.ill_cnt}, {7'b1000000, 5'd0, 8'd1}); else n_pass++;
        drive(1'b1, itype(6'h0D, 5'd1, 5'd9, 16'h00FF));
        tick;
        drive(1'b1, itype(6'h05, 5'd3, 5'd5, 16'd8));
        tick;
        drive(1'b1, {6'h03, 26'd64});
        tick;
        n_total++; if ({ctl, bus.dest, bus.ill_cnt} !== {7'b1000000, 5'd0, 8'd4})
            $display("FAIL ext_others_illegal got %h want %h", {ctl, bus.dest, bus.ill_cnt}, {7'b1000000, 5'd0, 8'd4}); else n_pass++;
`endif
        drive(1'b0, '0);
        tick;
    endtask

    task automatic test_reset_mid_stall;
        drive(1'b1, itype(6'h2B, 5'd1, 5'd2, 16'd4));
        tick;
        bus.out_ready = 1'b0;
        drive(1'b1, itype(6'h04, 5'd3, 5'd5, 16'd8));
        tick;
        n_total++; if (ctl !== 7'b1001001) $display("FAIL rs_stalled got %b want 1001001", ctl); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if ({ctl, bus.alu_control, bus.rs, bus.rt, bus.dest, bus.ill_cnt} !== 33'd0)
            $display("FAIL rs_async_clear got %h want 0",
                     {ctl, bus.alu_control, bus.rs, bus.rt, bus.dest, bus.ill_cnt}); else n_pass++;
        bus.out_ready = 1'b1;
        drive(1'b0, '0);
        rst = 1'b0;
        tick;
        n_total++; if (ctl !== 7'b0) $display("FAIL rs_discarded got %b want 0", ctl); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_rtype;
        test_load_use;
        test_backpressure;
        test_flush;
        test_illegal;
        test_ext_ops;
        test_reset_mid_stall;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
